// File: rtl/neo_pixel_receiver.sv
// rtl/neo_pixel_receiver.sv - NeoPixel serial stream decoder with staged/committed GRB frame store
module neo_pixel_receiver #(
  parameter int NUM_PIXELS   = 5,
  parameter int BIT_THRESH   = 27,
  parameter int MIN_HIGH     = 8,
  parameter int MAX_HIGH     = 56,
  parameter int LATCH_CYCLES = 2500
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        neo_data,
  input  logic [2:0]  rd_pixel_index,
  input  logic [1:0]  rd_color_index,
  output logic [7:0]  rd_color_level,
  output logic [23:0] pixel_word,
  output logic        pixel_valid,
  output logic        frame_done,
  output logic [3:0]  frame_pixels,
  output logic        bit_error,
  output logic        busy
);

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

  localparam logic [3:0]  NUM_P  = 4'(NUM_PIXELS);
  localparam logic [5:0]  THRESH = 6'(BIT_THRESH);
  localparam logic [5:0]  MIN_H  = 6'(MIN_HIGH);
  localparam logic [5:0]  MAX_H  = 6'(MAX_HIGH);
  localparam logic [11:0] LATCH  = 12'(LATCH_CYCLES);

  logic        s1, s2, s3;
  logic        rise, fall;
  state_t      state, state_next;
  logic [5:0]  high_cnt;
  logic [11:0] low_cnt;
  logic [4:0]  bit_cnt;
  logic [3:0]  word_cnt;
  logic [23:0] shreg;
  logic [23:0] staging   [0:7];
  logic [23:0] committed [0:7];
  logic [23:0] new_word;
  logic [23:0] rd_word;

  logic latch_hit, too_long, glitch, bit_accept, word_done, low_latch, bit_value;

  assign rise     = s2 & ~s3;
  assign fall     = ~s2 & s3;
  assign new_word = {shreg[22:0], bit_value};
  assign busy     = (state == HIGH) || (state == LOW);

  // Bring the line into the clock domain and keep one extra stage for edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= neo_data;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= SYNC;
    else       state <= state_next;
  end

  // Next-state decode; in LOW the latch takes priority over a coincident rise
  always_comb begin
    state_next = state;
    case (state)
      SYNC: if (!s2 && latch_hit) state_next = IDLE;
      IDLE: if (rise) state_next = HIGH;
      HIGH: begin
        if (too_long || glitch) state_next = SYNC;
        else if (bit_accept)    state_next = LOW;
      end
      LOW: begin
        if (low_latch) state_next = IDLE;
        else if (rise) state_next = HIGH;
      end
      default: state_next = SYNC;
    endcase
  end

  // Per-state control strobes steering the datapath
  always_comb begin
    latch_hit  = (low_cnt == LATCH);
    bit_value  = (high_cnt >= THRESH);
    too_long   = 1'b0;
    glitch     = 1'b0;
    bit_accept = 1'b0;
    word_done  = 1'b0;
    low_latch  = 1'b0;
    case (state)
      HIGH: begin
        too_long   = (high_cnt > MAX_H);
        glitch     = !too_long && fall && (high_cnt < MIN_H);
        bit_accept = !too_long && fall && (high_cnt >= MIN_H);
        word_done  = bit_accept && (bit_cnt == 5'd23);
      end
      LOW:     low_latch = latch_hit;
      default: ;
    endcase
  end

  // Counters, shift register, staging/committed arrays and registered pulse outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      high_cnt     <= '0;
      low_cnt      <= '0;
      bit_cnt      <= '0;
      word_cnt     <= '0;
      shreg        <= '0;
      pixel_word   <= '0;
      pixel_valid  <= 1'b0;
      frame_done   <= 1'b0;
      frame_pixels <= '0;
      bit_error    <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        staging[i]   <= '0;
        committed[i] <= '0;
      end
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      bit_error   <= 1'b0;
      case (state)
        SYNC: begin
          // Nothing gathered before alignment is trustworthy
          word_cnt <= '0;
          bit_cnt  <= '0;
          if (s2 || latch_hit) low_cnt <= '0;
          else                 low_cnt <= low_cnt + 12'd1;
        end
        IDLE: begin
          if (rise) high_cnt <= 6'd1;
        end
        HIGH: begin
          if (too_long) begin
            bit_error <= 1'b1;
            word_cnt  <= '0;
            bit_cnt   <= '0;
            low_cnt   <= '0;
          end else if (glitch) begin
            bit_error <= 1'b1;
            low_cnt   <= '0;
          end else if (bit_accept) begin
            shreg   <= new_word;
            low_cnt <= 12'd1;
            if (word_done) begin
              bit_cnt     <= '0;
              pixel_word  <= new_word;
              pixel_valid <= 1'b1;
              // Words beyond the array size are reported but not stored
              if (word_cnt < NUM_P) begin
                staging[word_cnt[2:0]] <= new_word;
                word_cnt               <= word_cnt + 4'd1;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end else if (high_cnt != 6'd63) begin
            high_cnt <= high_cnt + 6'd1;
          end
        end
        LOW: begin
          if (low_latch) begin
            if (bit_cnt != 5'd0) begin
              bit_error <= 1'b1;
            end else if (word_cnt != 4'd0) begin
              for (int i = 0; i < 8; i++) begin
                if (4'(i) < word_cnt) committed[i] <= staging[i];
              end
              frame_pixels <= word_cnt;
              frame_done   <= 1'b1;
            end
            word_cnt <= '0;
            bit_cnt  <= '0;
            low_cnt  <= '0;
          end else if (rise) begin
            high_cnt <= 6'd1;
          end else begin
            low_cnt <= low_cnt + 12'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Read port over the committed frame only; unstored slots and the reserved colour read 0
  always_comb begin
    rd_word        = committed[rd_pixel_index];
    rd_color_level = '0;
    if ({1'b0, rd_pixel_index} < NUM_P) begin
      case (rd_color_index)
        2'b00:   rd_color_level = rd_word[15:8];
        2'b01:   rd_color_level = rd_word[7:0];
        2'b10:   rd_color_level = rd_word[23:16];
        default: rd_color_level = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_neo_pixel_receiver.sv
// tb/tb_neo_pixel_receiver.sv - scoreboard bench for neo_pixel_receiver
module tb_neo_pixel_receiver;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        neo_data = 1'b0;
  logic [2:0]  rd_pixel_index = '0;
  logic [1:0]  rd_color_index = '0;
  logic [7:0]  rd_color_level;
  logic [23:0] pixel_word;
  logic        pixel_valid;
  logic        frame_done;
  logic [3:0]  frame_pixels;
  logic        bit_error;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [23:0] exp_words[$];
  int          exp_frames[$];
  string       exp_errs[$];
  int n_pv_exp = 0, n_fd_exp = 0, n_err_exp = 0;
  int n_pv_seen = 0, n_fd_seen = 0, n_err_seen = 0;

  neo_pixel_receiver dut (
    .clock          (clock),
    .reset          (reset),
    .neo_data       (neo_data),
    .rd_pixel_index (rd_pixel_index),
    .rd_color_index (rd_color_index),
    .rd_color_level (rd_color_level),
    .pixel_word     (pixel_word),
    .pixel_valid    (pixel_valid),
    .frame_done     (frame_done),
    .frame_pixels   (frame_pixels),
    .bit_error      (bit_error),
    .busy           (busy)
  );

  always #10 clock = ~clock;

  // Monitor: pops the scoreboard whenever the DUT emits an event
  always @(posedge clock) begin
    #1;
    if (pixel_valid) begin
      n_pv_seen++;
      checks++;
      if (exp_words.size() == 0) begin
        errors++;
        $display("FAIL pixel_valid unexpected: got word %h, none expected", pixel_word);
      end else begin
        logic [23:0] w;
        w = exp_words.pop_front();
        if (pixel_word !== w) begin
          errors++;
          $display("FAIL pixel_word: got %h expected %h", pixel_word, w);
        end
      end
    end
    if (frame_done) begin
      n_fd_seen++;
      checks++;
      if (exp_frames.size() == 0) begin
        errors++;
        $display("FAIL frame_done unexpected: got frame_pixels %0d, none expected", frame_pixels);
      end else begin
        int f;
        f = exp_frames.pop_front();
        if (frame_pixels !== 4'(f)) begin
          errors++;
          $display("FAIL frame_pixels: got %0d expected %0d", frame_pixels, f);
        end
      end
    end
    if (bit_error) begin
      n_err_seen++;
      checks++;
      if (exp_errs.size() == 0) begin
        errors++;
        $display("FAIL bit_error unexpected: got 1 expected 0");
      end else begin
        void'(exp_errs.pop_front());
      end
    end
  end

  task automatic drive(input logic v, input int n);
    neo_data = v;
    repeat (n) @(negedge clock);
  endtask

  task automatic send_pulse(input int h);
    drive(1'b1, h);
    drive(1'b0, 63 - h);
  endtask

  task automatic send_word(input logic [23:0] w, input bit expect_out);
    if (expect_out) begin
      exp_words.push_back(w);
      n_pv_exp++;
    end
    for (int i = 23; i >= 0; i--) send_pulse(w[i] ? 35 : 18);
  endtask

  task automatic latch(input int frame_n);
    if (frame_n > 0) begin
      exp_frames.push_back(frame_n);
      n_fd_exp++;
    end
    drive(1'b0, 2600);
  endtask

  task automatic expect_err(input string tag);
    exp_errs.push_back(tag);
    n_err_exp++;
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_rd(input string name, input logic [2:0] pix, input logic [1:0] col,
                          input logic [7:0] exp);
    rd_pixel_index = pix;
    rd_color_index = col;
    #1;
    check_val(name, 32'(rd_color_level), 32'(exp));
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, " pixel_word"},   32'(pixel_word),   32'h0);
    check_val({tag, " pixel_valid"},  32'(pixel_valid),  32'h0);
    check_val({tag, " frame_done"},   32'(frame_done),   32'h0);
    check_val({tag, " frame_pixels"}, 32'(frame_pixels), 32'h0);
    check_val({tag, " bit_error"},    32'(bit_error),    32'h0);
    check_val({tag, " busy"},         32'(busy),         32'h0);
    check_rd({tag, " rd p0 G"}, 3'd0, 2'b10, 8'h00);
    check_rd({tag, " rd p2 R"}, 3'd2, 2'b00, 8'h00);
  endtask

  logic [23:0] frame_a [0:4];
  logic [23:0] over_w  [0:5];

  initial begin
    frame_a[0] = 24'h123456; frame_a[1] = 24'hA55A0F; frame_a[2] = 24'hFF0081;
    frame_a[3] = 24'h01807E; frame_a[4] = 24'hC33C99;
    over_w[0] = 24'h111111; over_w[1] = 24'h222222; over_w[2] = 24'h333333;
    over_w[3] = 24'h444444; over_w[4] = 24'h5A6B7C; over_w[5] = 24'hEEDDCC;

    repeat (3) @(negedge clock);
    check_idle_outputs("reset");
    reset = 1'b0;

    // Line activity before alignment: nothing may be decoded
    drive(1'b0, 1000);
    send_word(24'hABCDEF, 1'b0);
    latch(0);
    check_val("idle busy", 32'(busy), 32'h0);

    // Full five-word frame
    for (int i = 0; i < 5; i++) send_word(frame_a[i], 1'b1);
    latch(5);
    check_val("frame_pixels after frame", 32'(frame_pixels), 32'd5);
    check_rd("p2 G",  3'd2, 2'b10, 8'hFF);
    check_rd("p2 R",  3'd2, 2'b00, 8'h00);
    check_rd("p2 B",  3'd2, 2'b01, 8'h81);
    check_rd("p0 R",  3'd0, 2'b00, 8'h34);
    check_rd("p4 B",  3'd4, 2'b01, 8'h99);
    check_rd("p2 reserved", 3'd2, 2'b11, 8'h00);
    check_rd("p5 out of range", 3'd5, 2'b10, 8'h00);

    // Thresholds: 27 -> 1, 26 -> 0, 56 -> 1 (longest legal), rest zeros
    exp_words.push_back(24'h800001);
    n_pv_exp++;
    send_pulse(27);
    send_pulse(26);
    for (int i = 0; i < 21; i++) send_pulse(18);
    send_pulse(56);
    latch(1);
    check_rd("thresh p0 G", 3'd0, 2'b10, 8'h80);
    check_rd("thresh p0 B", 3'd0, 2'b01, 8'h01);
    check_rd("thresh p1 G kept", 3'd1, 2'b10, 8'hA5);

    // Glitch and over-long highs
    expect_err("glitch");
    send_pulse(7);
    latch(0);
    expect_err("too long");
    drive(1'b1, 57);
    latch(0);

    // Partial frame: one word plus six bits
    send_word(24'h0FF03C, 1'b1);
    for (int i = 0; i < 6; i++) send_pulse((i % 2 == 0) ? 35 : 18);
    expect_err("partial");
    latch(0);
    check_rd("partial p0 G kept", 3'd0, 2'b10, 8'h80);
    check_val("partial frame_pixels", 32'(frame_pixels), 32'd1);

    // Overflow: sixth word reported but dropped
    for (int i = 0; i < 6; i++) send_word(over_w[i], 1'b1);
    latch(5);
    check_rd("ovf p4 G", 3'd4, 2'b10, 8'h5A);
    check_rd("ovf p4 R", 3'd4, 2'b00, 8'h6B);
    check_rd("ovf p4 B", 3'd4, 2'b01, 8'h7C);
    check_rd("ovf p0 R", 3'd0, 2'b00, 8'h11);

    // Reset mid-frame after three words
    for (int i = 0; i < 3; i++) send_word(frame_a[i], 1'b1);
    drive(1'b1, 10);
    #3 reset = 1'b1;
    neo_data = 1'b0;
    repeat (3) @(negedge clock);
    check_idle_outputs("midreset");
    check_rd("midreset p4 G", 3'd4, 2'b10, 8'h00);
    reset = 1'b0;
    latch(0);
    send_word(24'h0A0B0C, 1'b1);
    send_word(24'h102030, 1'b1);
    latch(2);
    check_rd("post p0 B", 3'd0, 2'b01, 8'h0C);
    check_rd("post p1 G", 3'd1, 2'b10, 8'h10);
    check_rd("post p2 G cleared", 3'd2, 2'b10, 8'h00);
    check_val("post frame_pixels", 32'(frame_pixels), 32'd2);

    repeat (5) @(negedge clock);
    check_val("pixel_valid count", 32'(n_pv_seen), 32'(n_pv_exp));
    check_val("frame_done count",  32'(n_fd_seen), 32'(n_fd_exp));
    check_val("bit_error count",   32'(n_err_seen), 32'(n_err_exp));
    check_val("words left", 32'(exp_words.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
